// File: rtl/d8m_cfg_pkg.sv
// rtl/d8m_cfg_pkg.sv - shared types and constants for the D8M configuration sequencer
//
// Purpose : table entry layout, special device codes and FSM state encodings.
// Macro   : CFG_READBACK_EN adds the two read-back states and the read-data comparator.
package d8m_cfg_pkg;

   // Table entry layout: [39:33] dev7, [32] wide, [31:16] reg, [15:0] data
   localparam int ENTRY_W     = 40;
   localparam int ENT_DEV_HI  = 39;
   localparam int ENT_DEV_LO  = 33;
   localparam int ENT_WIDE    = 32;
   localparam int ENT_REG_HI  = 31;
   localparam int ENT_REG_LO  = 16;
   localparam int ENT_DATA_HI = 15;
   localparam int ENT_DATA_LO = 0;

   localparam logic [6:0] DEV_DELAY = 7'h00;
   localparam logic [6:0] DEV_END   = 7'h7F;

   typedef struct packed {
      logic [6:0]  dev;
      logic        wide;
      logic [15:0] reg_addr;
      logic [15:0] data;
   } cfg_entry_t;

   // FSM state encodings
   localparam int         ST_W        = 4;
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_RST_HOLD = 4'd1;
   localparam logic [3:0] ST_SETTLE   = 4'd2;
   localparam logic [3:0] ST_FETCH_A  = 4'd3;
   localparam logic [3:0] ST_FETCH_D  = 4'd4;
   localparam logic [3:0] ST_DECODE   = 4'd5;
   localparam logic [3:0] ST_ISSUE    = 4'd6;
   localparam logic [3:0] ST_WAIT     = 4'd7;
   localparam logic [3:0] ST_DELAY    = 4'd8;
   localparam logic [3:0] ST_NEXT     = 4'd9;
   localparam logic [3:0] ST_DONE     = 4'd10;
   localparam logic [3:0] ST_ERROR    = 4'd11;
`ifdef CFG_READBACK_EN
   localparam logic [3:0] ST_RD_ISSUE = 4'd12;
   localparam logic [3:0] ST_RD_WAIT  = 4'd13;
`endif

   function automatic cfg_entry_t decode_entry(input logic [ENTRY_W-1:0] raw);
      cfg_entry_t e;
      e.dev      = raw[ENT_DEV_HI:ENT_DEV_LO];
      e.wide     = raw[ENT_WIDE];
      e.reg_addr = raw[ENT_REG_HI:ENT_REG_LO];
      e.data     = raw[ENT_DATA_HI:ENT_DATA_LO];
      return e;
   endfunction

`ifdef CFG_READBACK_EN
   // A byte-wide register only returns its low byte meaningfully
   function automatic logic rb_match(input cfg_entry_t e, input logic [15:0] rdata);
      if (e.wide) return rdata == e.data;
      return rdata[7:0] == e.data[7:0];
   endfunction
`endif

endpackage

// File: rtl/d8m_cfg_sequencer_if.sv
// rtl/d8m_cfg_sequencer_if.sv - transaction-level I2C master request/response bundle
//
// Purpose : groups the sequencer <-> I2C master handshake.
// Ports   : i2c_req/i2c_gnt request handshake; i2c_dev/i2c_reg/i2c_data/i2c_wide/i2c_rd
//           transaction fields; i2c_done/i2c_nack/i2c_rdata completion response.
interface d8m_cfg_sequencer_if;
   logic        i2c_req;
   logic        i2c_gnt;
   logic [6:0]  i2c_dev;
   logic [15:0] i2c_reg;
   logic [15:0] i2c_data;
   logic        i2c_wide;
   logic        i2c_rd;
   logic        i2c_done;
   logic        i2c_nack;
   logic [15:0] i2c_rdata;

   modport master (
      output i2c_req, i2c_dev, i2c_reg, i2c_data, i2c_wide, i2c_rd,
      input  i2c_gnt, i2c_done, i2c_nack, i2c_rdata
   );

   modport slave (
      input  i2c_req, i2c_dev, i2c_reg, i2c_data, i2c_wide, i2c_rd,
      output i2c_gnt, i2c_done, i2c_nack, i2c_rdata
   );
endinterface

// File: rtl/d8m_cfg_timer.sv
// rtl/d8m_cfg_timer.sv - cycle counter plus millisecond prescaled down-counter
//
// Purpose : times the reset hold / settle intervals in cycles and delay entries in ms.
// Ports   : clk, rst_n (async active-low);
//           cyc_load/cyc_val -> cyc_expired (counter at zero);
//           ms_load/ms_val   -> ms_expired  (final tick of the last ms reached).
module d8m_cfg_timer #(
   parameter int CLK_HZ = 50_000_000,
   parameter int CYC_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cyc_load,
   input  logic [CYC_W-1:0] cyc_val,
   output logic             cyc_expired,
   input  logic             ms_load,
   input  logic [15:0]      ms_val,
   output logic             ms_expired
);

   localparam int TICK  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK - 1);

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [15:0]      ms_q,  ms_d;

   always_comb begin
      cyc_d = cyc_q;
      if (cyc_load)          cyc_d = cyc_val;
      else if (cyc_q != '0)  cyc_d = cyc_q - 1'b1;
   end

   // Prescaler restarts on every load so a delay is measured from the load edge
   always_comb begin
      pre_d = pre_q;
      ms_d  = ms_q;
      if (ms_load) begin
         pre_d = PRE_MAX;
         ms_d  = ms_val;
      end else if (ms_q != '0) begin
         if (pre_q == '0) begin
            pre_d = PRE_MAX;
            ms_d  = ms_q - 1'b1;
         end else begin
            pre_d = pre_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         pre_q <= '0;
         ms_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end

   assign cyc_expired = (cyc_q == '0);
   // Flag expiry on the last cycle of the final ms so n ms spans exactly n*TICK cycles
   assign ms_expired  = (ms_q == '0) || (ms_q == 16'd1 && pre_q == '0);

endmodule

// File: rtl/d8m_cfg_sequencer.sv
// rtl/d8m_cfg_sequencer.sv - D8M MIPI bridge power-up reset and register table sequencer
//
// Purpose : holds the bridge in reset, lets it settle, then writes each ROM table entry
//           through the I2C master with NACK retry and ms delay entries.
// Ports   : clk_clk, reset_reset_n (async active-low), start pulse;
//           rom_addr/rom_data table ROM (data one cycle after address);
//           i2c master-modport bundle; mipi_reset_n bridge reset;
//           busy/done/error status and err_index of the failing entry.
// Macro   : CFG_READBACK_EN enables read-back verification of every acknowledged write.
module d8m_cfg_sequencer
   import d8m_cfg_pkg::*;
#(
   parameter int  CLK_HZ          = 50_000_000,
   parameter int  RST_HOLD_CYCLES = 1000,
   parameter int  SETTLE_CYCLES   = 50000,
   parameter int  N_ENTRIES       = 256,
   parameter int  MAX_RETRY       = 3,
   localparam int IDX_W           = $clog2(N_ENTRIES)
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 start,
   output logic [IDX_W-1:0]     rom_addr,
   input  logic [ENTRY_W-1:0]   rom_data,
   d8m_cfg_sequencer_if.master  i2c,
   output logic                 mipi_reset_n,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [IDX_W-1:0]     err_index
);

   localparam int CYC_MAX = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CYC_W-1:0]   HOLD_LOAD   = CYC_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CYC_W-1:0]   SETTLE_LOAD = CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
   localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_ENTRIES - 1);

   logic [ST_W-1:0]    state_q,     state_d;
   logic [IDX_W-1:0]   index_q,     index_d;
   logic [IDX_W-1:0]   err_index_q, err_index_d;
   logic [RETRY_W-1:0] retry_q,     retry_d;
   cfg_entry_t         entry_q,     entry_d;
   logic               req_q,       req_d;
   logic [6:0]         dev_q,       dev_d;
   logic [15:0]        reg_q,       reg_d;
   logic [15:0]        data_q,      data_d;
   logic               wide_q,      wide_d;
   logic               mipi_q,      mipi_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic               error_q,     error_d;
`ifdef CFG_READBACK_EN
   logic               rd_q,        rd_d;
`endif

   logic               cyc_load, cyc_expired;
   logic [CYC_W-1:0]   cyc_val;
   logic               ms_load, ms_expired;
   logic               attempt_failed;

   d8m_cfg_timer #(
      .CLK_HZ (CLK_HZ),
      .CYC_W  (CYC_W)
   ) u_timer (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .cyc_load    (cyc_load),
      .cyc_val     (cyc_val),
      .cyc_expired (cyc_expired),
      .ms_load     (ms_load),
      .ms_val      (entry_q.data),
      .ms_expired  (ms_expired)
   );

   always_comb begin
      state_d        = state_q;
      index_d        = index_q;
      err_index_d    = err_index_q;
      retry_d        = retry_q;
      entry_d        = entry_q;
      req_d          = req_q;
      dev_d          = dev_q;
      reg_d          = reg_q;
      data_d         = data_q;
      wide_d         = wide_q;
      mipi_d         = mipi_q;
      busy_d         = busy_q;
      done_d         = done_q;
      error_d        = error_q;
`ifdef CFG_READBACK_EN
      rd_d           = rd_q;
`endif
      cyc_load       = 1'b0;
      cyc_val        = '0;
      ms_load        = 1'b0;
      attempt_failed = 1'b0;

      case (state_q)
         // start is only honoured while not busy; mid-sequence pulses fall through
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_index_d = '0;
               index_d     = '0;
               retry_d     = '0;
               mipi_d      = 1'b0;
               busy_d      = 1'b1;
               cyc_load    = 1'b1;
               cyc_val     = HOLD_LOAD;
               state_d     = ST_RST_HOLD;
            end
         end
         ST_RST_HOLD: begin
            if (cyc_expired) begin
               mipi_d   = 1'b1;
               cyc_load = 1'b1;
               cyc_val  = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cyc_expired) state_d = ST_FETCH_A;
         end
         ST_FETCH_A: state_d = ST_FETCH_D;
         ST_FETCH_D: begin
            entry_d = decode_entry(rom_data);
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (entry_q.dev == DEV_END) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (entry_q.dev == DEV_DELAY) begin
               if (entry_q.data == 16'd0) begin
                  state_d = ST_NEXT;
               end else begin
                  ms_load = 1'b1;
                  state_d = ST_DELAY;
               end
            end else begin
               dev_d   = entry_q.dev;
               reg_d   = entry_q.reg_addr;
               data_d  = entry_q.data;
               wide_d  = entry_q.wide;
               req_d   = 1'b1;
`ifdef CFG_READBACK_EN
               rd_d    = 1'b0;
`endif
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (i2c.i2c_gnt) begin
               req_d   = 1'b0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i2c.i2c_done) begin
               if (i2c.i2c_nack) begin
                  attempt_failed = 1'b1;
               end else begin
`ifdef CFG_READBACK_EN
                  req_d   = 1'b1;
                  rd_d    = 1'b1;
                  state_d = ST_RD_ISSUE;
`else
                  state_d = ST_NEXT;
`endif
               end
            end
         end
`ifdef CFG_READBACK_EN
         ST_RD_ISSUE: begin
            if (i2c.i2c_gnt) begin
               req_d   = 1'b0;
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (i2c.i2c_done) begin
               rd_d = 1'b0;
               if (!i2c.i2c_nack && rb_match(entry_q, i2c.i2c_rdata)) state_d = ST_NEXT;
               else                                                     attempt_failed = 1'b1;
            end
         end
`endif
         ST_DELAY: begin
            if (ms_expired) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            retry_d = '0;
            if (index_q == IDX_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               index_d = index_q + 1'b1;
               state_d = ST_FETCH_A;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every failed attempt (write NACK, or read-back NACK/mismatch) restarts from the write
      if (attempt_failed) begin
         if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            req_d   = 1'b1;
`ifdef CFG_READBACK_EN
            rd_d    = 1'b0;
`endif
            state_d = ST_ISSUE;
         end else begin
            busy_d      = 1'b0;
            error_d     = 1'b1;
            err_index_d = index_q;
            state_d     = ST_ERROR;
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         err_index_q <= '0;
         retry_q     <= '0;
         entry_q     <= '0;
         req_q       <= 1'b0;
         dev_q       <= '0;
         reg_q       <= '0;
         data_q      <= '0;
         wide_q      <= 1'b0;
         mipi_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef CFG_READBACK_EN
         rd_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         err_index_q <= err_index_d;
         retry_q     <= retry_d;
         entry_q     <= entry_d;
         req_q       <= req_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         wide_q      <= wide_d;
         mipi_q      <= mipi_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef CFG_READBACK_EN
         rd_q        <= rd_d;
`endif
      end
   end

   assign rom_addr      = index_q;
   assign i2c.i2c_req   = req_q;
   assign i2c.i2c_dev   = dev_q;
   assign i2c.i2c_reg   = reg_q;
   assign i2c.i2c_data  = data_q;
   assign i2c.i2c_wide  = wide_q;
`ifdef CFG_READBACK_EN
   assign i2c.i2c_rd    = rd_q;
`else
   assign i2c.i2c_rd    = 1'b0;
   logic unused_rdata;
   assign unused_rdata  = ^i2c.i2c_rdata;
`endif
   assign mipi_reset_n  = mipi_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_index     = err_index_q;

endmodule

// File: tb/tb_d8m_cfg_sequencer.sv
// tb/tb_d8m_cfg_sequencer.sv - scoreboard bench for d8m_cfg_sequencer
module tb_d8m_cfg_sequencer;

   localparam int CLK_HZ    = 10000;
   localparam int RST_HOLD  = 8;
   localparam int SETTLE    = 4;
   localparam int N_ENTRIES = 256;
   localparam int MAX_RETRY = 3;
   localparam int IDX_W     = 8;

   typedef struct packed {
      logic [6:0]  dev;
      logic [15:0] rg;
      logic [15:0] data;
      logic        wide;
      logic        rd;
   } req_t;

   typedef struct packed {
      logic             done;
      logic             error;
      logic [IDX_W-1:0] idx;
      logic             mipi;
      logic             busy;
   } stat_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [IDX_W-1:0] rom_addr;
   logic [39:0]      rom_data = '0;
   logic             mipi_reset_n, busy, done, error;
   logic [IDX_W-1:0] err_index;
   logic [39:0]      rom [N_ENTRIES];

   d8m_cfg_sequencer_if i2c_bus ();

   d8m_cfg_sequencer #(
      .CLK_HZ          (CLK_HZ),
      .RST_HOLD_CYCLES (RST_HOLD),
      .SETTLE_CYCLES   (SETTLE),
      .N_ENTRIES       (N_ENTRIES),
      .MAX_RETRY       (MAX_RETRY)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (reset_n),
      .start         (start),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .i2c           (i2c_bus),
      .mipi_reset_n  (mipi_reset_n),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .err_index     (err_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   int    n_checks = 0;
   int    n_fail   = 0;
   req_t  exp_req_q[$];
   stat_t exp_stat_q[$];
   bit    nack_q[$];
   logic [15:0] rdq[$];
   bit    hold_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] mk(input logic [6:0] dev, input logic wide,
                                      input logic [15:0] rg, input logic [15:0] data);
      return {dev, wide, rg, data};
   endfunction

   function automatic req_t to_req(input logic [39:0] e, input logic rd);
      return '{dev: e[39:33], rg: e[31:16], data: e[15:0], wide: e[32], rd: rd};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < N_ENTRIES; i++) rom[i] = {7'h7F, 33'h0};
   endtask

   task automatic exp_wr(input logic [39:0] e, input bit nack);
      exp_req_q.push_back(to_req(e, 1'b0));
      nack_q.push_back(nack);
`ifdef CFG_READBACK_EN
      if (!nack) begin
         exp_req_q.push_back(to_req(e, 1'b1));
         rdq.push_back(e[15:0]);
      end
`endif
   endtask

   task automatic exp_status(input logic dn, input logic er, input logic [IDX_W-1:0] idx);
      exp_stat_q.push_back('{done: dn, error: er, idx: idx, mipi: 1'b1, busy: 1'b0});
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_mipi"},   mipi_reset_n,       0);
      chk({tag, "_req"},    i2c_bus.i2c_req,    0);
      chk({tag, "_rd"},     i2c_bus.i2c_rd,     0);
      chk({tag, "_busy"},   busy,               0);
      chk({tag, "_done"},   done,               0);
      chk({tag, "_error"},  error,              0);
      chk({tag, "_addr"},   rom_addr,           0);
      chk({tag, "_erridx"}, err_index,          0);
      chk({tag, "_fields"}, {i2c_bus.i2c_dev, i2c_bus.i2c_reg, i2c_bus.i2c_data, i2c_bus.i2c_wide}, 0);
   endtask

   // I2C master model: grants immediately, completes the cycle after grant
   initial begin
      bit          pend = 0;
      bit          pend_nack = 0;
      logic [15:0] pend_rdata = '0;
      i2c_bus.i2c_gnt   = 1'b0;
      i2c_bus.i2c_done  = 1'b0;
      i2c_bus.i2c_nack  = 1'b0;
      i2c_bus.i2c_rdata = '0;
      forever begin
         @(negedge clk);
         i2c_bus.i2c_gnt  = 1'b0;
         i2c_bus.i2c_done = 1'b0;
         i2c_bus.i2c_nack = 1'b0;
         if (!reset_n) begin
            pend = 0;
         end else if (pend) begin
            if (!hold_done) begin
               i2c_bus.i2c_done  = 1'b1;
               i2c_bus.i2c_nack  = pend_nack;
               i2c_bus.i2c_rdata = pend_rdata;
               pend = 0;
            end
         end else if (i2c_bus.i2c_req) begin
            i2c_bus.i2c_gnt = 1'b1;
            pend = 1;
            if (i2c_bus.i2c_rd) begin
               pend_nack  = 0;
               pend_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'hDEAD;
            end else begin
               pend_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            end
         end
      end
   end

   // Monitor: compares every granted request and every busy fall against the scoreboard
   initial begin
      logic  busy_prev = 1'b0;
      req_t  act_req, exp_req;
      stat_t act_stat, exp_st;
      forever begin
         @(negedge clk);
         #1;
         if (reset_n) begin
            if (i2c_bus.i2c_req && i2c_bus.i2c_gnt) begin
               act_req = '{dev: i2c_bus.i2c_dev, rg: i2c_bus.i2c_reg, data: i2c_bus.i2c_data,
                           wide: i2c_bus.i2c_wide, rd: i2c_bus.i2c_rd};
               if (exp_req_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_req: got %0h expected none", act_req);
               end else begin
                  exp_req = exp_req_q.pop_front();
                  chk("i2c_req_fields", act_req, exp_req);
               end
            end
            if (busy_prev && !busy) begin
               act_stat = '{done: done, error: error, idx: err_index, mipi: mipi_reset_n, busy: busy};
               if (exp_stat_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_status: got %0h expected none", act_stat);
               end else begin
                  exp_st = exp_stat_q.pop_front();
                  chk("final_status", act_stat, exp_st);
               end
            end
         end
         busy_prev = busy;
      end
   end

   // Runs one sequence; c_rise/c_done are cycle offsets from the first busy cycle
   task automatic run_test(input string name, input bit poke, output int c_rise, output int c_done);
      int low_cnt = 0;
      bit fin = 0;
      c_rise = -1;
      c_done = -1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({name, "_busy_after_start"}, busy, 1);
      for (int c = 0; c < 3000; c++) begin
         if (busy && !mipi_reset_n) low_cnt++;
         if (mipi_reset_n && c_rise < 0) c_rise = c;
         if (!busy) begin
            c_done = c;
            fin = 1;
            break;
         end
         start = poke && (c_rise >= 0) && (c == c_rise + 1);
         @(negedge clk);
      end
      start = 1'b0;
      chk({name, "_finished"}, fin, 1);
      chk({name, "_mipi_low_cycles"}, low_cnt, RST_HOLD);
      repeat (3) @(negedge clk);
   endtask

   logic [39:0] ent_a, ent_b0, ent_b1, ent_b2;

   initial begin
      int r, d, dly;
      bit saw_req;
      ent_a  = mk(7'h1C, 1'b0, 16'h0004, 16'h0004);
      ent_b0 = mk(7'h1C, 1'b1, 16'h3000, 16'h1234);
      ent_b1 = mk(7'h36, 1'b0, 16'h0100, 16'h00A5);
      ent_b2 = mk(7'h1C, 1'b1, 16'h0205, 16'hBEEF);
      clear_rom();

      repeat (3) @(negedge clk);
      check_reset_vals("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("after_reset");

      // Basic single write
      clear_rom();
      rom[0] = ent_a;
      exp_wr(ent_a, 0);
      exp_status(1, 0, 0);
      run_test("basic", 0, r, d);

      // 3 ms delay, then a 0 ms delay: DONE lands 45 cycles after mipi rises
      // (4 settle + 2 fetch + decode, 30 delay, next + 2 fetch + decode, next + 2 fetch + decode)
      clear_rom();
      rom[0] = mk(7'h00, 1'b0, 16'h0000, 16'd3);
      rom[1] = mk(7'h00, 1'b0, 16'h0000, 16'd0);
      exp_status(1, 0, 0);
      run_test("delay", 0, r, d);
      dly = d - r;
      n_checks++;
      if (dly < 44 || dly > 46) begin
         n_fail++;
         $display("FAIL delay_timing: got %0d cycles expected 45 +/-1", dly);
      end

      // Index 2 NACKed three times, then accepted
      clear_rom();
      rom[0] = ent_b0;
      rom[1] = ent_b1;
      rom[2] = ent_b2;
      exp_wr(ent_b0, 0);
      exp_wr(ent_b1, 0);
      for (int i = 0; i < 3; i++) exp_wr(ent_b2, 1);
      exp_wr(ent_b2, 0);
      exp_status(1, 0, 0);
      run_test("retry_ok", 0, r, d);

      // Index 2 NACKed four times: retries exhausted
      exp_wr(ent_b0, 0);
      exp_wr(ent_b1, 0);
      for (int i = 0; i < 4; i++) exp_wr(ent_b2, 1);
      exp_status(0, 1, 8'd2);
      run_test("retry_fail", 0, r, d);

      // Reset asserted while waiting on the transaction
      clear_rom();
      rom[0] = ent_a;
      exp_req_q.push_back(to_req(ent_a, 1'b0));
      nack_q.push_back(1'b0);
      hold_done = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      saw_req = 0;
      for (int c = 0; c < 200; c++) begin
         if (i2c_bus.i2c_req) begin
            saw_req = 1;
            break;
         end
         @(negedge clk);
      end
      chk("mid_rst_saw_req", saw_req, 1);
      @(negedge clk);
      chk("mid_rst_busy_in_wait", busy, 1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals("mid_rst");
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      hold_done = 1'b0;
      repeat (2) @(negedge clk);

      // start pulsed during SETTLE is ignored
      clear_rom();
      rom[0] = ent_a;
      exp_wr(ent_a, 0);
      exp_status(1, 0, 0);
      run_test("settle_start", 1, r, d);

`ifdef CFG_READBACK_EN
      // Read-back 0x0005 for a 0x0004 write forces a retry; 0xAB04 matches a byte-wide entry
      exp_req_q.push_back(to_req(ent_a, 1'b0));
      nack_q.push_back(1'b0);
      exp_req_q.push_back(to_req(ent_a, 1'b1));
      rdq.push_back(16'h0005);
      exp_req_q.push_back(to_req(ent_a, 1'b0));
      nack_q.push_back(1'b0);
      exp_req_q.push_back(to_req(ent_a, 1'b1));
      rdq.push_back(16'hAB04);
      exp_status(1, 0, 0);
      run_test("rb_retry", 0, r, d);

      for (int i = 0; i < 4; i++) begin
         exp_req_q.push_back(to_req(ent_a, 1'b0));
         nack_q.push_back(1'b0);
         exp_req_q.push_back(to_req(ent_a, 1'b1));
         rdq.push_back(16'h0005);
      end
      exp_status(0, 1, 8'd0);
      run_test("rb_fail", 0, r, d);
`endif

      repeat (5) @(negedge clk);
      chk("req_queue_drained",    exp_req_q.size(),  0);
      chk("status_queue_drained", exp_stat_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
